// File: rtl/ps2_rx_ctrl_pkg.sv
// Shared types and constants for the PS/2 keyboard receive controller.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int STAT_NE    = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_PERR  = 2;
  localparam int STAT_FERR  = 3;
  localparam int STAT_OVF   = 4;
  localparam int STAT_TOERR = 5;
  localparam int STAT_IRQEN = 7;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// CPU-side slave bus of the PS/2 receive controller.
interface ps2_rx_ctrl_if;
  logic       s_cs_n;
  logic       s_address;
  logic       s_read;
  logic       s_write;
  logic [7:0] s_writedata;
  logic [7:0] s_readdata;

  modport master (
    output s_cs_n, s_address, s_read, s_write, s_writedata,
    input  s_readdata
  );

  modport slave (
    input  s_cs_n, s_address, s_read, s_write, s_writedata,
    output s_readdata
  );
endinterface

// File: rtl/ps2_fifo.sv
// Synchronous scancode FIFO; extra pointer MSB separates full from empty on wrap.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: clock conditioning, frame FSM with watchdog,
// scancode FIFO, status/control registers and maskable interrupt.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FILT_LEN   = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic          clk,
  input  logic          reset_n,
  ps2_rx_ctrl_if.slave  bus,
  output logic          irq,
  input  logic          kc,
  input  logic          kd
);
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT - 1);

  logic kc_meta_r, kc_sync_r, kd_meta_r, kd_sync_r;
  logic kc_f_r, kc_f_d_r, fall_s;
  logic [FW-1:0] filt_cnt_r;
  logic [WW-1:0] wd_cnt_r;

  ps2_state_e state_r, state_nxt_s, fsm_nxt_s;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic       par_r;
  logic       timeout_s, push_s, perr_set_s, ferr_set_s;

  logic rd_s, wr_s, pop_s, ctrl_wr_s, fifo_push_s, ovf_set_s;
  logic fifo_full_s, fifo_empty_s;
  logic [7:0] fifo_dout_s, status_s;
  logic perr_r, ferr_r, ovf_r, toerr_r, irq_en_r, irq_r;
  logic unused_wdata_s;

  // Two-flop synchronisers, idle high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_meta_r <= 1'b1;
      kc_sync_r <= 1'b1;
      kd_meta_r <= 1'b1;
      kd_sync_r <= 1'b1;
    end else begin
      kc_meta_r <= kc;
      kc_sync_r <= kc_meta_r;
      kd_meta_r <= kd;
      kd_sync_r <= kd_meta_r;
    end
  end

  // Clock filter: adopt the synced value after FILT_LEN stable cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_f_r     <= 1'b1;
      kc_f_d_r   <= 1'b1;
      filt_cnt_r <= '0;
    end else begin
      kc_f_d_r <= kc_f_r;
      if (kc_sync_r != kc_f_r) begin
        if (filt_cnt_r == FILT_MAX) begin
          kc_f_r     <= kc_sync_r;
          filt_cnt_r <= '0;
        end else begin
          filt_cnt_r <= filt_cnt_r + 1'b1;
        end
      end else begin
        filt_cnt_r <= '0;
      end
    end
  end

  assign fall_s = kc_f_d_r & ~kc_f_r;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // FSM next state and frame verdict
  always_comb begin
    fsm_nxt_s  = state_r;
    push_s     = 1'b0;
    perr_set_s = 1'b0;
    ferr_set_s = 1'b0;
    timeout_s  = (state_r != ST_IDLE) && !fall_s && (wd_cnt_r == WD_MAX);
    case (state_r)
      ST_IDLE:   fsm_nxt_s = (fall_s && !kd_sync_r) ? ST_DATA : ST_IDLE;
      ST_DATA:   fsm_nxt_s = (fall_s && (bit_cnt_r == 3'd7)) ? ST_PARITY : ST_DATA;
      ST_PARITY: fsm_nxt_s = fall_s ? ST_STOP : ST_PARITY;
      ST_STOP: begin
        if (fall_s) begin
          fsm_nxt_s = ST_IDLE;
          if (!parity_ok(shift_r, par_r)) perr_set_s = 1'b1;
          else if (!kd_sync_r)            ferr_set_s = 1'b1;
          else                            push_s     = 1'b1;
        end else begin
          fsm_nxt_s = ST_STOP;
        end
      end
      default:   fsm_nxt_s = ST_IDLE;
    endcase
    state_nxt_s = timeout_s ? ST_IDLE : fsm_nxt_s;
  end

  // Frame datapath: bit counter, LSB-first shifter, parity capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE:   bit_cnt_r <= 3'd0;
        ST_DATA: begin
          shift_r   <= {kd_sync_r, shift_r[7:1]};
          bit_cnt_r <= bit_cnt_r + 1'b1;
        end
        ST_PARITY: par_r <= kd_sync_r;
        default:   par_r <= par_r;
      endcase
    end
  end

  // Watchdog: cycles since the last fall while a frame is open
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             wd_cnt_r <= '0;
    else if (state_r == ST_IDLE || fall_s)    wd_cnt_r <= '0;
    else if (wd_cnt_r != WD_MAX)              wd_cnt_r <= wd_cnt_r + 1'b1;
  end

  // Bus decode; a write colliding with a read is dropped
  assign rd_s        = ~bus.s_cs_n & bus.s_read;
  assign wr_s        = ~bus.s_cs_n & bus.s_write & ~bus.s_read;
  assign pop_s       = rd_s & (bus.s_address == ADDR_DATA) & ~fifo_empty_s;
  assign ctrl_wr_s   = wr_s & (bus.s_address == ADDR_STAT);
  assign fifo_push_s = push_s & (~fifo_full_s | pop_s);
  assign ovf_set_s   = push_s & fifo_full_s & ~pop_s;
  assign unused_wdata_s = ^{bus.s_writedata[6], bus.s_writedata[1:0]};

  ps2_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push_s),
    .pop     (pop_s),
    .din     (shift_r),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Sticky flags (set beats W1C), IRQ enable and registered interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      ovf_r    <= 1'b0;
      toerr_r  <= 1'b0;
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      perr_r  <= perr_set_s | (perr_r  & ~(ctrl_wr_s & bus.s_writedata[STAT_PERR]));
      ferr_r  <= ferr_set_s | (ferr_r  & ~(ctrl_wr_s & bus.s_writedata[STAT_FERR]));
      ovf_r   <= ovf_set_s  | (ovf_r   & ~(ctrl_wr_s & bus.s_writedata[STAT_OVF]));
      toerr_r <= timeout_s  | (toerr_r & ~(ctrl_wr_s & bus.s_writedata[STAT_TOERR]));
      irq_en_r <= ctrl_wr_s ? bus.s_writedata[STAT_IRQEN] : irq_en_r;
      irq_r   <= irq_en_r & (~fifo_empty_s | perr_r | ferr_r | ovf_r | toerr_r);
    end
  end

  assign irq = irq_r;

  // Status word and read-data mux
  always_comb begin
    status_s             = 8'h00;
    status_s[STAT_NE]    = ~fifo_empty_s;
    status_s[STAT_FULL]  = fifo_full_s;
    status_s[STAT_PERR]  = perr_r;
    status_s[STAT_FERR]  = ferr_r;
    status_s[STAT_OVF]   = ovf_r;
    status_s[STAT_TOERR] = toerr_r;
    status_s[STAT_IRQEN] = irq_en_r;
    if (bus.s_address == ADDR_DATA) bus.s_readdata = fifo_empty_s ? 8'h00 : fifo_dout_s;
    else                            bus.s_readdata = status_s;
  end
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl with a scancode scoreboard queue.
module tb_ps2_rx_ctrl;
  localparam int DEPTH   = 8;
  localparam int FILT    = 8;
  localparam int TMO     = 600;
  localparam int HALF    = 30;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic kc = 1'b1;
  logic kd = 1'b1;
  logic irq;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rdata;

  ps2_rx_ctrl_if bus_if ();

  ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .FILT_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .irq     (irq),
    .kc      (kc),
    .kd      (kd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.s_cs_n = 1'b1; bus_if.s_read = 1'b0; bus_if.s_write = 1'b0;
    bus_if.s_address = 1'b0; bus_if.s_writedata = 8'h00;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    @(posedge clk); #1;
    bus_if.s_cs_n = 1'b0; bus_if.s_write = 1'b1; bus_if.s_address = a; bus_if.s_writedata = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    @(posedge clk); #1;
    bus_if.s_cs_n = 1'b0; bus_if.s_read = 1'b1; bus_if.s_address = a;
    @(negedge clk);
    d = bus_if.s_readdata;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic read_status(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(1'b1, d);
    check(tag, d, exp);
  endtask

  // DATA read compared against the scoreboard head (0x00 when nothing is due)
  task automatic read_data(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    bus_read(1'b0, d);
    check(tag, d, e);
  endtask

  task automatic ps2_bit(input logic b);
    kd = b;
    repeat (HALF) @(posedge clk);
    #1 kc = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 kc = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(data[i]);
    ps2_bit(par);
    ps2_bit(stop);
    kd = 1'b1;
    repeat (HALF) @(posedge clk);
    if (((^data) ^ par) && stop && exp_q.size() < DEPTH) exp_q.push_back(data);
  endtask

  task automatic send_good(input logic [7:0] data);
    send_frame(data, ~(^data), 1'b1);
  endtask

  initial begin
    bus_idle();
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);

    check("reset_irq", {7'd0, irq}, 8'h00);
    read_status("reset_status", 8'h00);
    read_data("reset_data");

    // Valid frame, interrupt disabled
    send_frame(8'h1C, 1'b0, 1'b1);
    read_status("valid_status", 8'h01);
    check("valid_irq_masked", {7'd0, irq}, 8'h00);
    read_data("valid_data");
    read_status("valid_status_after", 8'h00);

    // Valid frame with interrupt enabled
    bus_write(1'b1, 8'h80);
    send_good(8'h1C);
    check("irq_high", {7'd0, irq}, 8'h01);
    read_status("irq_status", 8'h81);
    read_data("irq_data");
    @(posedge clk); #1;
    check("irq_low", {7'd0, irq}, 8'h00);
    bus_write(1'b1, 8'h00);

    // Parity error
    send_frame(8'h1C, 1'b1, 1'b1);
    read_status("perr_status", 8'h04);
    bus_write(1'b1, 8'h04);
    read_status("perr_clear", 8'h00);

    // Overflow
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    read_status("ovf_status", 8'h13);
    for (int i = 0; i < 8; i++) read_data($sformatf("ovf_data%0d", i));
    read_data("ovf_empty_read");
    read_status("ovf_after", 8'h10);
    bus_write(1'b1, 8'h10);
    read_status("ovf_clear", 8'h00);

    // Glitch one cycle shorter than the filter
    @(posedge clk); #1 kc = 1'b0;
    repeat (FILT - 1) @(posedge clk);
    #1 kc = 1'b1;
    repeat (40) @(posedge clk);
    read_status("glitch_status", 8'h00);
    send_good(8'h33);
    read_data("glitch_next_frame");

    // Framing error
    send_frame(8'h1C, 1'b0, 1'b0);
    read_status("ferr_status", 8'h08);
    bus_write(1'b1, 8'h08);
    read_status("ferr_clear", 8'h00);

    // Watchdog timeout after a lone start bit
    ps2_bit(1'b0);
    kd = 1'b1;
    repeat (TMO - 100) @(posedge clk);
    read_status("toerr_before", 8'h00);
    repeat (200) @(posedge clk);
    read_status("toerr_status", 8'h20);
    bus_write(1'b1, 8'h20);
    send_good(8'h5A);
    read_status("toerr_recover_status", 8'h01);
    read_data("toerr_recover_data");

    // Reset in the middle of a frame
    bus_write(1'b1, 8'h80);
    send_good(8'h11);
    check("pre_reset_irq", {7'd0, irq}, 8'h01);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    #1 reset_n = 1'b0;
    kc = 1'b1; kd = 1'b1;
    exp_q.delete();
    #2;
    check("reset_irq_async", {7'd0, irq}, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    read_status("midreset_status", 8'h00);
    read_data("midreset_data");
    send_good(8'h5A);
    read_data("midreset_next_frame");
    read_status("final_status", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_ctrl.md
# ps2_rx_ctrl

PS/2 keyboard receive controller that sits between the raw `kc`/`kd` keyboard lines and the CPU-side slave bus.
- Synchronises and de-glitches the PS/2 clock.
- Sequences the 11-bit frame receiver and checks parity, start and stop bits.
- Buffers scancodes in a FIFO.
- Raises a maskable interrupt.

It replaces free-running scancode sampling with a framed, flow-controlled receive path for the keyboard peripheral.

## Interface
- `FIFO_DEPTH`, 8: scancode FIFO entries; power of two, 2..64.
- `FILT_LEN`, 8: consecutive stable samples required before the filtered PS/2 clock changes.
- `TIMEOUT`, 50000: `clk` cycles allowed between falling edges of the filtered PS/2 clock inside a frame.
- `clk` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `irq` out 1: level interrupt to the CPU.
- `s_cs_n` in 1: slave chip select, active low.
- `s_address` in 1: 0 = DATA, 1 = STATUS/CTRL.
- `s_read` in 1: read strobe, one cycle per access.
- `s_readdata` out 8: read data, combinational from the address mux.
- `s_write` in 1: write strobe.
- `s_writedata` in 8: write data.
- `kc` in 1: PS/2 clock from the keyboard, asynchronous.
- `kd` in 1: PS/2 data from the keyboard, asynchronous.

## Operation
**Input conditioning**
- `kc` and `kd` each pass through a 2-flop synchroniser.
- `kc_f` (filtered clock) takes the synced `kc` value only after that value has been stable for `FILT_LEN` consecutive cycles.
- `fall` is a one-cycle pulse on the 1→0 transition of `kc_f`; the synced `kd` is sampled on `fall`.

**Frame FSM** (`fall` is the only advancing event; all states except IDLE arm the watchdog)
- IDLE:
  - `fall` with `kd`=0 → DATA, bit count = 0.
  - `fall` with `kd`=1 → stay in IDLE (spurious edge, no flag).
- DATA: shift `kd` in LSB first; after the 8th bit → PARITY.
- PARITY: capture the parity bit; → STOP.
- STOP: on `fall`:
  - If ones(data)+parity is even → set PERR and discard the byte.
  - Else if `kd`=0 → set FERR and discard the byte.
  - Else push the byte.
  - Then → IDLE.
- Watchdog: counts `clk` cycles since the last `fall` while not in IDLE. On reaching `TIMEOUT` → set TOERR, discard the partial byte, → IDLE.

**FIFO**
- Push when full: drop the byte and set OVF (sticky).
- Read of DATA: `s_readdata` = head entry and pop.
- Read of DATA when empty: returns 0x00, no pop, no flag.
- Write to DATA is ignored.

**STATUS read** (bit assignment)
- bit0: not-empty
- bit1: full
- bit2: PERR
- bit3: FERR
- bit4: OVF
- bit5: TOERR
- bit6: 0
- bit7: IRQ_EN

**CTRL write**
- bit7 loads IRQ_EN.
- bits[5:2] are write-1-to-clear for the corresponding flags.
- All other bits are ignored.

**Interrupt**
- `irq` is registered: `irq` <= IRQ_EN & (not-empty | PERR | FERR | OVF | TOERR).

**Reset values**
- `irq`=0, IRQ_EN=0, FIFO empty, all flags 0, FSM in IDLE, watchdog 0.
- Synchronisers and filter reset to 1; `kc_f`=1 (bus idle high).
- `s_readdata` reflects the reset state: DATA reads 0x00, STATUS reads 0x00.
- Reset asserted mid-frame discards the partial byte with no flag.

## Timing
- Filter latency: a raw `kc` edge reaches `kc_f` after 2 + `FILT_LEN` cycles.
- Push occurs on the clock edge ending the `fall` cycle in STOP. Not-empty is visible in STATUS on the next cycle; `irq` rises one cycle after that.
- Bus accesses have zero wait states:
  - `s_readdata` is valid in the cycle that `~s_cs_n & s_read` is high.
  - Pop, flag clear and IRQ_EN update all take effect on that cycle's clock edge.
- Simultaneous push and pop:
  - When full: the pop frees a slot, the push succeeds, OVF is not set.
  - When empty: the read returns 0x00 and the push succeeds.
- Simultaneous flag set and W1C on the same flag: set wins.
- Simultaneous read and write strobes: the write is ignored.
- Watchdog reloads on every `fall`. A frame with bit gaps of exactly `TIMEOUT`-1 cycles is accepted.

## Structure
- Package `ps2_pkg` holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Address constants `ADDR_DATA`=0, `ADDR_STAT`=1.
  - STATUS bit-index constants.
- Sub-module `ps2_fifo`: synchronous FIFO parameterised by depth and width.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers are log2(depth)+1 bits wide so full and empty are distinguishable on wrap-around.
- Synchroniser, filter, FSM, watchdog, registers and bus mux stay in the top level.

## Test plan
- Valid frame: keyboard sends 0x1C with parity 0 and stop 1 → STATUS=0x01. DATA read returns 0x1C, then STATUS=0x00. With IRQ_EN=1, `irq` is high between the push and the read.
- Parity error: 0x1C sent with parity 1 → FIFO stays empty and STATUS=0x04. Writing 0x04 to CTRL → STATUS=0x00.
- Overflow: 9 frames 0x01..0x09 with `FIFO_DEPTH`=8 → STATUS=0x13. Eight DATA reads return 0x01..0x08 in order; a 9th read returns 0x00.
- Glitch and framing:
  - A `kc` low pulse of `FILT_LEN`-1 cycles → no bit is sampled and the FSM stays in IDLE.
  - A frame with stop bit 0 → STATUS=0x08, FIFO empty.
- Timeout and reset:
  - Start bit followed by no further edges → TOERR set after `TIMEOUT` cycles; the next valid 0x5A frame is received correctly.
  - `reset_n` asserted after 4 data bits → all outputs at reset values; the following 0x5A frame is received correctly.
